// File: rtl/axi_ram_responder_pkg.sv
// Shared response codes, burst counter width and FSM state types for the AXI RAM responder.
package axi_ram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One count per beat of an up-to-256-beat INCR burst (beat index 0..255).
  localparam int BEAT_CNT_W = 8;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_DATA
  } rd_state_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// INCR burst address helper: maps (start address, beat number) to a RAM word index,
// flags beats that fall outside the RAM and marks the final beat of the burst.
module axi_burst_addr
  import axi_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int STRB       = 8,
  parameter int MEM_WORDS  = 1024
) (
  input  logic [ADDR_WIDTH-1:0]        start_addr,
  input  logic [BEAT_CNT_W-1:0]        len,
  input  logic [BEAT_CNT_W-1:0]        beat,
  output logic [$clog2(MEM_WORDS)-1:0] mem_idx,
  output logic                         in_range,
  output logic                         last
);

  localparam int OFFS   = $clog2(STRB);
  localparam int RAM_AW = $clog2(MEM_WORDS);

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] word;

  // Sum is taken in ADDR_WIDTH bits so a burst crossing the top of the space wraps to 0.
  always_comb begin
    beat_addr = start_addr + (ADDR_WIDTH'(beat) << OFFS);
    word      = beat_addr >> OFFS;
    in_range  = word < ADDR_WIDTH'(MEM_WORDS);
    mem_idx   = word[RAM_AW-1:0];
    last      = (beat == len);
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a word-addressed RAM: independent single-outstanding write and read
// engines, INCR bursts, byte strobes, SLVERR on out-of-range beats, programmable read latency.
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int READ_WAIT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB   = DATA_WIDTH / 8;
  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int WAIT_W = 8;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- write engine state ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] wstart_q, wstart_d;
  logic [BEAT_CNT_W-1:0] wlen_q, wlen_d;
  logic [BEAT_CNT_W-1:0] wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [RAM_AW-1:0]     w_idx;
  logic                  w_in_range, w_last;
  logic                  mem_we;

  // ---------------- read engine state ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] rstart_q, rstart_d;
  logic [BEAT_CNT_W-1:0] rlen_q, rlen_d;
  logic [BEAT_CNT_W-1:0] rbeat_q, rbeat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [BEAT_CNT_W-1:0] r_len, r_beat;
  logic [RAM_AW-1:0]     r_idx;
  logic                  r_in_range, r_last;
  logic                  load_beat;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB       (STRB),
    .MEM_WORDS  (MEM_WORDS)
  ) u_wr_addr (
    .start_addr (wstart_q),
    .len        (wlen_q),
    .beat       (wbeat_q),
    .mem_idx    (w_idx),
    .in_range   (w_in_range),
    .last       (w_last)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    wstart_d   = wstart_q;
    wlen_d     = wlen_q;
    wbeat_d    = wbeat_q;
    werr_d     = werr_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wid_d      = s_axi_awid;
          wstart_d   = s_axi_awaddr;
          wlen_d     = BEAT_CNT_W'(s_axi_awlen);
          wbeat_d    = '0;
          werr_d     = 1'b0;
          wr_state_d = WR_DATA;
        end
      end
      // The beat count alone closes the burst; a wlast that disagrees only poisons bresp.
      WR_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we  = w_in_range;
          wbeat_d = wbeat_q + BEAT_CNT_W'(1);
          if (w_last) begin
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bid_d      = wid_q;
            bresp_d    = resp_of(werr_q || !w_in_range || !s_axi_wlast);
            wr_state_d = WR_RESP;
          end else begin
            werr_d = werr_q || !w_in_range || s_axi_wlast;
          end
        end
      end
      WR_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wid_q      <= '0;
      wstart_q   <= '0;
      wlen_q     <= '0;
      wbeat_q    <= '0;
      werr_q     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      wstart_q   <= wstart_d;
      wlen_q     <= wlen_d;
      wbeat_q    <= wbeat_d;
      werr_q     <= werr_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // While idle the helper looks at the incoming AR so a zero-wait read can load beat 0 at accept.
  always_comb begin
    r_start = rstart_q;
    r_len   = rlen_q;
    r_beat  = rbeat_q;
    if (rd_state_q == RD_IDLE) begin
      r_start = s_axi_araddr;
      r_len   = BEAT_CNT_W'(s_axi_arlen);
      r_beat  = '0;
    end
  end

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB       (STRB),
    .MEM_WORDS  (MEM_WORDS)
  ) u_rd_addr (
    .start_addr (r_start),
    .len        (r_len),
    .beat       (r_beat),
    .mem_idx    (r_idx),
    .in_range   (r_in_range),
    .last       (r_last)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rstart_d   = rstart_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    wait_d     = wait_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    load_beat  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rid_d     = s_axi_arid;
          rstart_d  = s_axi_araddr;
          rlen_d    = BEAT_CNT_W'(s_axi_arlen);
          rbeat_d   = '0;
          wait_d    = WAIT_W'(READ_WAIT - 1);
          if (READ_WAIT == 0) begin
            load_beat  = 1'b1;
            rd_state_d = RD_DATA;
          end else begin
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          load_beat  = 1'b1;
          rd_state_d = RD_DATA;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RD_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = RD_IDLE;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    // The RAM is read before this edge's write lands, so a colliding read sees old data.
    if (load_beat) begin
      rvalid_d = 1'b1;
      rdata_d  = r_in_range ? mem[r_idx] : '0;
      rresp_d  = resp_of(!r_in_range);
      rlast_d  = r_last;
      rbeat_d  = r_beat + BEAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rstart_q   <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      wait_q     <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rstart_q   <= rstart_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      wait_q     <= wait_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed plus randomized bench for axi_ram_responder against a byte-level RAM model.
module tb_axi_ram_responder;

  localparam int RW   = 3;
  localparam int MEMW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0;
  logic [27:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [27:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] model [MEMW];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];
  logic [63:0] rdBuf [256];
  logic [1:0]  rrBuf [256];
  logic        rlBuf [256];
  logic [3:0]  riBuf [256];
  int          rdLat;

  axi_ram_responder #(
    .ADDR_WIDTH (28),
    .DATA_WIDTH (64),
    .ID_WIDTH   (4),
    .MEM_WORDS  (MEMW),
    .READ_WAIT  (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout, expected self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: apply a burst to the byte model, return the response it deserves.
  function automatic logic [1:0] modelWrite(input logic [27:0] a, input int len, input int lastAt);
    logic err;
    logic [27:0] ba;
    int w;
    err = (lastAt != len);
    for (int b = 0; b <= len; b++) begin
      ba = a + 28'(b * 8);
      w  = int'(ba >> 3);
      if (w < MEMW) begin
        for (int y = 0; y < 8; y++)
          if (wstb[b][y]) model[w][y*8 +: 8] = wdat[b][y*8 +: 8];
      end else begin
        err = 1'b1;
      end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic applyStimulus(input logic [27:0] a, input int len, input int lastAt,
                               input logic [3:0] id, output logic [1:0] resp, output logic [3:0] gotId);
    int t;
    bit done;
    awaddr = a; awlen = 8'(len); awid = id; awvalid = 1'b1;
    done = 0; t = 0;
    while (!done && t < 50) begin done = awready; stepClk(); t++; end
    awvalid = 1'b0;
    checkOutput("aw_accept", 64'(done), 64'd1);
    for (int b = 0; b <= len; b++) begin
      wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == lastAt); wvalid = 1'b1;
      done = 0; t = 0;
      while (!done && t < 50) begin done = wready; stepClk(); t++; end
      if (!done) checkOutput("w_accept", 64'd0, 64'd1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("wready_drop", 64'(wready), 64'd0);
    checkOutput("bvalid_rise", 64'(bvalid), 64'd1);
    bready = 1'b1; done = 0; t = 0; resp = 2'bxx; gotId = 4'hx;
    while (!done && t < 50) begin done = bvalid; resp = bresp; gotId = bid; stepClk(); t++; end
    bready = 1'b0;
    checkOutput("b_handshake", 64'(done), 64'd1);
    checkOutput("awready_back", 64'(awready), 64'd1);
  endtask

  // mode 0: rready held high, 1: toggling 1/0, 2: random
  task automatic readBurst(input logic [27:0] a, input int len, input logic [3:0] id, input int mode);
    int t, cycles, beat;
    bit done, stalled;
    logic [63:0] held;
    araddr = a; arlen = 8'(len); arid = id; arvalid = 1'b1;
    done = 0; t = 0;
    while (!done && t < 50) begin done = arready; stepClk(); t++; end
    arvalid = 1'b0;
    checkOutput("ar_accept", 64'(done), 64'd1);
    cycles = 1;
    while (!rvalid && cycles < 50) begin stepClk(); cycles++; end
    rdLat = cycles;
    beat = 0; t = 0; stalled = 0; held = '0;
    while (beat <= len && t < 3000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      if (stalled) begin
        checkOutput("r_hold_valid", 64'(rvalid), 64'd1);
        checkOutput("r_hold_data", rdata, held);
      end
      stalled = 0;
      if (rvalid) begin
        if (rready) begin
          rdBuf[beat] = rdata; rrBuf[beat] = rresp; rlBuf[beat] = rlast; riBuf[beat] = rid;
          beat++;
        end else begin
          stalled = 1; held = rdata;
        end
      end
      stepClk();
      t++;
    end
    rready = 1'b0;
    checkOutput("r_beats", 64'(beat), 64'(len + 1));
    checkOutput("r_valid_drop", 64'(rvalid), 64'd0);
    checkOutput("arready_back", 64'(arready), 64'd1);
  endtask

  task automatic compareRead(input logic [27:0] a, input int len, input logic [3:0] id);
    logic [27:0] ba;
    int w;
    checkOutput("r_latency", 64'(rdLat), 64'(1 + RW));
    for (int b = 0; b <= len; b++) begin
      ba = a + 28'(b * 8);
      w  = int'(ba >> 3);
      checkOutput($sformatf("r_data[%0d]", b), rdBuf[b], (w < MEMW) ? model[w] : 64'd0);
      checkOutput($sformatf("r_resp[%0d]", b), 64'(rrBuf[b]), (w < MEMW) ? 64'd0 : 64'd2);
      checkOutput($sformatf("r_last[%0d]", b), 64'(rlBuf[b]), 64'(b == len));
      checkOutput($sformatf("r_id[%0d]", b), 64'(riBuf[b]), 64'(id));
    end
  endtask

  initial begin
    logic [1:0]  resp, expResp;
    logic [3:0]  gotId;
    logic [63:0] firstBeat2;
    logic [27:0] a;
    int l, t, beats;

    // reset: every output low while rst is held
    repeat (3) stepClk();
    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_wready", 64'(wready), 64'd0);
    checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    stepClk();
    checkOutput("post_rst_awready", 64'(awready), 64'd1);
    checkOutput("post_rst_arready", 64'(arready), 64'd1);

    // prefill words 0..255 with a max-length burst so later reads see known data
    for (int b = 0; b < 256; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    expResp = modelWrite(28'h0, 255, 255);
    applyStimulus(28'h0, 255, 255, 4'h1, resp, gotId);
    checkOutput("prefill_bresp", 64'(resp), 64'(expResp));

    // single beat at 0x40
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
    expResp = modelWrite(28'h40, 0, 0);
    applyStimulus(28'h40, 0, 0, 4'h5, resp, gotId);
    checkOutput("single_bresp", 64'(resp), 64'd0);
    checkOutput("single_bid", 64'(gotId), 64'h5);
    readBurst(28'h40, 0, 4'h6, 0);
    checkOutput("single_rdata", rdBuf[0], 64'h1122334455667788);
    checkOutput("single_rresp", 64'(rrBuf[0]), 64'd0);
    checkOutput("single_rlast", 64'(rlBuf[0]), 64'd1);
    compareRead(28'h40, 0, 4'h6);

    // 4-beat at 0x100, then rewrite with strobe 0x0F on beat 2
    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    firstBeat2 = wdat[2];
    expResp = modelWrite(28'h100, 3, 3);
    applyStimulus(28'h100, 3, 3, 4'h2, resp, gotId);
    checkOutput("burst4_bresp", 64'(resp), 64'(expResp));
    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = (b == 2) ? 8'h0F : 8'hFF; end
    expResp = modelWrite(28'h100, 3, 3);
    applyStimulus(28'h100, 3, 3, 4'h3, resp, gotId);
    checkOutput("strobe_bresp", 64'(resp), 64'(expResp));
    readBurst(28'h100, 3, 4'h4, 1);
    checkOutput("strobe_upper_kept", 64'(rdBuf[2][63:32]), 64'(firstBeat2[63:32]));
    checkOutput("strobe_lower_new", 64'(rdBuf[2][31:0]), 64'(wdat[2][31:0]));
    compareRead(28'h100, 3, 4'h4);

    // straddle the top of the RAM
    a = 28'(MEMW * 8 - 8);
    for (int b = 0; b < 2; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    expResp = modelWrite(a, 1, 1);
    applyStimulus(a, 1, 1, 4'h7, resp, gotId);
    checkOutput("oor_bresp", 64'(resp), 64'd2);
    readBurst(a, 1, 4'h8, 0);
    checkOutput("oor_b0_resp", 64'(rrBuf[0]), 64'd0);
    checkOutput("oor_b1_resp", 64'(rrBuf[1]), 64'd2);
    checkOutput("oor_b1_data", rdBuf[1], 64'd0);
    compareRead(a, 1, 4'h8);

    // address space wrap: beat 0 far out of range, beat 1 lands on word 0
    a = 28'hFFFFFF8;
    for (int b = 0; b < 2; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    expResp = modelWrite(a, 1, 1);
    applyStimulus(a, 1, 1, 4'h9, resp, gotId);
    checkOutput("wrap_bresp", 64'(resp), 64'(expResp));
    readBurst(a, 1, 4'hA, 2);
    compareRead(a, 1, 4'hA);

    // early wlast on beat 1 of 4, then wlast never asserted
    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    expResp = modelWrite(28'h200, 3, 1);
    applyStimulus(28'h200, 3, 1, 4'hB, resp, gotId);
    checkOutput("early_wlast_bresp", 64'(resp), 64'd2);
    for (int b = 0; b < 4; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
    expResp = modelWrite(28'h220, 2, -1);
    applyStimulus(28'h220, 2, -1, 4'hC, resp, gotId);
    checkOutput("missing_wlast_bresp", 64'(resp), 64'd2);
    readBurst(28'h200, 7, 4'hD, 1);
    compareRead(28'h200, 7, 4'hD);

    // randomized write/read pairs
    for (int k = 0; k < 6; k++) begin
      a = 28'($urandom_range(0, 224) * 8 + $urandom_range(0, 7));
      l = $urandom_range(0, 15);
      for (int b = 0; b <= l; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'($urandom); end
      expResp = modelWrite(a, l, l);
      applyStimulus(a, l, l, 4'(k), resp, gotId);
      checkOutput("rand_bresp", 64'(resp), 64'(expResp));
      checkOutput("rand_bid", 64'(gotId), 64'(k));
      a = 28'($urandom_range(0, 240) * 8);
      l = $urandom_range(0, 15);
      readBurst(a, l, 4'(k + 3), 2);
      compareRead(a, l, 4'(k + 3));
    end

    // reset in the middle of an 8-beat read
    araddr = 28'h0; arlen = 8'd7; arid = 4'h2; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin stepClk(); t++; end
    stepClk();
    arvalid = 1'b0;
    rready = 1'b1; beats = 0; t = 0;
    while (beats < 2 && t < 50) begin
      if (rvalid) beats++;
      stepClk();
      t++;
    end
    checkOutput("midrst_beats", 64'(beats), 64'd2);
    rst = 1'b1;
    stepClk();
    checkOutput("midrst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("midrst_arready", 64'(arready), 64'd0);
    rst = 1'b0; rready = 1'b0;
    stepClk();
    checkOutput("midrst_arready_after", 64'(arready), 64'd1);
    checkOutput("midrst_rvalid_after", 64'(rvalid), 64'd0);

    // RAM survives reset
    readBurst(28'h40, 1, 4'hE, 0);
    compareRead(28'h40, 1, 4'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
